// File: rtl/ccff_loader_pkg.sv
// Shared types and constants for the configuration-chain loader.
package ccff_loader_pkg;

  // Loader FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  // CRC-8, polynomial x^8 + x^2 + x + 1, no reflection, no final XOR
  localparam logic [7:0] CRC_POLY = 8'h07;
  localparam logic [7:0] CRC_INIT = 8'h00;

endpackage

// File: rtl/ccff_crc8_step.sv
// One serial step of the CRC-8 used for head/tail signatures.
module ccff_crc8_step
  import ccff_loader_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic       bit_in,
  output logic [7:0] crc_out
);

  logic feedback;

  // Shift the CRC left by one and fold in the polynomial when the feedback bit is set
  always_comb begin
    feedback = crc_in[7] ^ bit_in;
    if (feedback) begin
      crc_out = {crc_in[6:0], 1'b0} ^ CRC_POLY;
    end else begin
      crc_out = {crc_in[6:0], 1'b0};
    end
  end

endmodule

// File: rtl/ccff_loader.sv
// Serialises configuration words into a flip-flop chain, signs both the
// bits sent and the bits returned by the chain tail, and compares the tail
// signature of this pass against the head signature of the previous pass.
module ccff_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 8,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [7:0]        tail_sig,
  output logic              match_valid,
  output logic              match
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int WL_W  = $clog2(WORD_W + 1);

  state_e            state_q;
  logic [WORD_W-1:0] shreg_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [CNT_W-1:0]  bit_cnt_d;
  logic [WL_W-1:0]   word_left_q;
  logic [7:0]        head_crc_q;
  logic [7:0]        head_crc_d;
  logic [7:0]        tail_crc_q;
  logic [7:0]        tail_crc_d;
  logic [7:0]        prev_head_crc_q;
  logic              prev_ok_q;
  logic [7:0]        tail_sig_q;
  logic              match_q;
  logic              match_valid_q;

  // Next bit count saturates at CHAIN_LEN so it can never wrap
  always_comb begin
    if (bit_cnt_q == CNT_W'(CHAIN_LEN)) begin
      bit_cnt_d = bit_cnt_q;
    end else begin
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
    end
  end

  // Chain-facing strobes: abort and reset must suppress shifting in the same cycle
  always_comb begin
    shift_en  = (state_q == SHIFT) && !abort && !prog_reset;
    cfg_ready = (state_q == FETCH) && !abort && !prog_reset;
    if (shift_en) begin
      ccff_head = shreg_q[WORD_W-1];
    end else begin
      ccff_head = 1'b0;
    end
  end

  ccff_crc8_step u_head_crc (
    .crc_in  (head_crc_q),
    .bit_in  (ccff_head),
    .crc_out (head_crc_d)
  );

  ccff_crc8_step u_tail_crc (
    .crc_in  (tail_crc_q),
    .bit_in  (ccff_tail),
    .crc_out (tail_crc_d)
  );

  // Loader FSM with datapath and result registers
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_q         <= IDLE;
      shreg_q         <= '0;
      bit_cnt_q       <= '0;
      word_left_q     <= '0;
      head_crc_q      <= CRC_INIT;
      tail_crc_q      <= CRC_INIT;
      prev_head_crc_q <= 8'h00;
      prev_ok_q       <= 1'b0;
      tail_sig_q      <= 8'h00;
      match_q         <= 1'b0;
      match_valid_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            bit_cnt_q  <= '0;
            head_crc_q <= CRC_INIT;
            tail_crc_q <= CRC_INIT;
            state_q    <= FETCH;
          end
        end
        FETCH: begin
          if (abort) begin
            prev_ok_q     <= 1'b0;
            match_valid_q <= 1'b0;
            state_q       <= IDLE;
          end else if (cfg_valid) begin
            shreg_q     <= cfg_data;
            word_left_q <= WL_W'(WORD_W);
            state_q     <= SHIFT;
          end
        end
        SHIFT: begin
          if (abort) begin
            prev_ok_q     <= 1'b0;
            match_valid_q <= 1'b0;
            state_q       <= IDLE;
          end else begin
            shreg_q     <= shreg_q << 1;
            head_crc_q  <= head_crc_d;
            tail_crc_q  <= tail_crc_d;
            bit_cnt_q   <= bit_cnt_d;
            word_left_q <= word_left_q - WL_W'(1);
            // A full chain ends the pass even if the current word has bits left
            if (bit_cnt_d == CNT_W'(CHAIN_LEN)) begin
              state_q <= DONE;
            end else if (word_left_q == WL_W'(1)) begin
              state_q <= FETCH;
            end
          end
        end
        DONE: begin
          tail_sig_q      <= tail_crc_q;
          match_q         <= (tail_crc_q == prev_head_crc_q);
          match_valid_q   <= prev_ok_q;
          prev_head_crc_q <= head_crc_q;
          prev_ok_q       <= 1'b1;
          state_q         <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign tail_sig    = tail_sig_q;
  assign match       = match_q;
  assign match_valid = match_valid_q;

endmodule

// File: tb/tb_ccff_loader.sv
// Scoreboard bench: two loaders (8-bit and 4-bit words) drive bench-side
// chain models; expected head bits and pass results are queued at stimulus
// time and compared when the loader shifts or completes a pass.
module tb_ccff_loader;

  logic prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  logic       prog_reset;
  logic       start8, abort8, cfg_valid8, ready8, head8, sen8, tail8, busy8, done8, mv8, m8;
  logic [7:0] data8, tsig8;
  logic       start4, abort4, cfg_valid4, ready4, head4, sen4, tail4, busy4, done4, mv4, m4;
  logic [3:0] data4;
  logic [7:0] tsig4;

  ccff_loader #(.CHAIN_LEN(8), .WORD_W(8)) dut8 (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start8), .abort(abort8),
    .cfg_data(data8), .cfg_valid(cfg_valid8), .cfg_ready(ready8), .ccff_head(head8),
    .shift_en(sen8), .ccff_tail(tail8), .busy(busy8), .done(done8), .tail_sig(tsig8),
    .match_valid(mv8), .match(m8)
  );

  ccff_loader #(.CHAIN_LEN(8), .WORD_W(4)) dut4 (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start4), .abort(abort4),
    .cfg_data(data4), .cfg_valid(cfg_valid4), .cfg_ready(ready4), .ccff_head(head4),
    .shift_en(sen4), .ccff_tail(tail4), .busy(busy4), .done(done4), .tail_sig(tsig4),
    .match_valid(mv4), .match(m4)
  );

  // Chain models: shift on prog_clk when enabled, tail is the last flop
  logic [7:0] chain8 = 8'h00;
  logic [7:0] chain4 = 8'h00;
  logic       stuck3 = 1'b0;
  assign tail8 = chain8[7];
  assign tail4 = chain4[7];

  always @(posedge prog_clk) begin
    if (sen8) chain8 <= stuck3 ? ({chain8[6:0], head8} & 8'hF7) : {chain8[6:0], head8};
    if (sen4) chain4 <= {chain4[6:0], head4};
  end

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Byte-wise CRC-8 (poly 0x07, init 0): message XORed in, then eight reductions
  function automatic logic [7:0] crc8(input logic [7:0] b);
    logic [7:0] c;
    c = b;
    for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
  endfunction

  // Scoreboard state
  bit         q8[$];
  bit         q4[$];
  logic [7:0] passq8[$];
  logic [7:0] passq4[$];
  int         shifts8 = 0, shifts4 = 0, dones8 = 0, dones4 = 0;

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  // Monitor for the 8-bit loader
  initial begin
    logic [7:0] tacc, prev_head, exp_ts, w;
    logic       prev_ok, pend, exp_m, exp_mv, sen_d, done_d;
    tacc = 8'h00; prev_head = 8'h00; prev_ok = 1'b0; pend = 1'b0;
    exp_ts = 8'h00; exp_m = 1'b0; exp_mv = 1'b0; sen_d = 1'b0; done_d = 1'b0;
    forever begin
      @(negedge prog_clk);
      if (prog_reset) begin
        q8.delete(); passq8.delete(); pend = 1'b0; prev_ok = 1'b0; prev_head = 8'h00;
      end else begin
        if (pend) begin
          chk("tail_sig8", 32'(tsig8), 32'(exp_ts));
          chk("match8", 32'(m8), 32'(exp_m));
          chk("match_valid8", 32'(mv8), 32'(exp_mv));
          pend = 1'b0;
        end
        if (!busy8) begin
          q8.delete(); passq8.delete(); tacc = 8'h00;
        end
        if (abort8 && busy8 && !done8) prev_ok = 1'b0;
        if (sen8) begin
          shifts8++;
          tacc = {tacc[6:0], tail8};
          if (q8.size() > 0) chk("head8", 32'(head8), 32'(q8.pop_front()));
          else chk("extra_shift8", 32'd1, 32'd0);
        end else begin
          chk("head8_idle", 32'(head8), 32'd0);
        end
        if (done8) begin
          dones8++;
          chk("done8_after_last_shift", 32'(sen_d), 32'd1);
          chk("done8_one_cycle", 32'(done_d), 32'd0);
          if (passq8.size() > 0) begin
            w      = passq8.pop_front();
            exp_ts = crc8(tacc);
            exp_m  = (exp_ts == crc8(prev_head));
            exp_mv = prev_ok;
            prev_head = w;
            prev_ok   = 1'b1;
            pend      = 1'b1;
          end else begin
            chk("unexpected_done8", 32'd1, 32'd0);
          end
        end
      end
      sen_d  = sen8;
      done_d = done8;
    end
  end

  // Monitor for the 4-bit-word loader
  initial begin
    logic [7:0] tacc, prev_head, exp_ts, w;
    logic       prev_ok, pend, exp_m, exp_mv;
    tacc = 8'h00; prev_head = 8'h00; prev_ok = 1'b0; pend = 1'b0;
    exp_ts = 8'h00; exp_m = 1'b0; exp_mv = 1'b0;
    forever begin
      @(negedge prog_clk);
      if (prog_reset) begin
        q4.delete(); passq4.delete(); pend = 1'b0; prev_ok = 1'b0; prev_head = 8'h00;
      end else begin
        if (pend) begin
          chk("tail_sig4", 32'(tsig4), 32'(exp_ts));
          chk("match4", 32'(m4), 32'(exp_m));
          chk("match_valid4", 32'(mv4), 32'(exp_mv));
          pend = 1'b0;
        end
        if (!busy4) begin
          q4.delete(); passq4.delete(); tacc = 8'h00;
        end
        if (abort4 && busy4 && !done4) prev_ok = 1'b0;
        if (sen4) begin
          shifts4++;
          tacc = {tacc[6:0], tail4};
          if (q4.size() > 0) chk("head4", 32'(head4), 32'(q4.pop_front()));
          else chk("extra_shift4", 32'd1, 32'd0);
        end else begin
          chk("head4_idle", 32'(head4), 32'd0);
        end
        if (done4) begin
          dones4++;
          if (passq4.size() > 0) begin
            w      = passq4.pop_front();
            exp_ts = crc8(tacc);
            exp_m  = (exp_ts == crc8(prev_head));
            exp_mv = prev_ok;
            prev_head = w;
            prev_ok   = 1'b1;
            pend      = 1'b1;
          end else begin
            chk("unexpected_done4", 32'd1, 32'd0);
          end
        end
      end
    end
  end

  task automatic start_pass(input bit sel4);
    if (sel4) start4 = 1'b1; else start8 = 1'b1;
    tick();
    start4 = 1'b0;
    start8 = 1'b0;
  endtask

  // Offer one word, queue its expected head bits, hold valid until accepted
  task automatic push_word(input bit sel4, input logic [7:0] w);
    int t;
    t = 0;
    if (!sel4) begin
      data8 = w; cfg_valid8 = 1'b1;
      while (!ready8 && t < 40) begin tick(); t++; end
      if (t >= 40) chk("ready8_timeout", 32'd0, 32'd1);
      else for (int i = 7; i >= 0; i--) q8.push_back(w[i]);
      tick();
      cfg_valid8 = 1'b0;
    end else begin
      data4 = w[3:0]; cfg_valid4 = 1'b1;
      while (!ready4 && t < 40) begin tick(); t++; end
      if (t >= 40) chk("ready4_timeout", 32'd0, 32'd1);
      else for (int i = 3; i >= 0; i--) q4.push_back(w[i]);
      tick();
      cfg_valid4 = 1'b0;
    end
  endtask

  task automatic wait_done(input bit sel4, input int base);
    int t;
    t = 0;
    while (((sel4 ? dones4 : dones8) == base) && t < 100) begin tick(); t++; end
    if (t >= 100) chk(sel4 ? "done4_timeout" : "done8_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_shifts(input bit sel4, input int base, input int n);
    int t;
    t = 0;
    while (((sel4 ? shifts4 : shifts8) - base) < n && t < 100) begin tick(); t++; end
    if (t >= 100) chk("shift_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int sh, dn;
    logic [7:0] snap;
    prog_reset = 1'b1;
    start8 = 1'b0; abort8 = 1'b0; cfg_valid8 = 1'b0; data8 = 8'h00;
    start4 = 1'b0; abort4 = 1'b0; cfg_valid4 = 1'b0; data4 = 4'h0;
    repeat (3) tick();

    // Reset state
    chk("rst_cfg_ready", 32'(ready8), 32'd0);
    chk("rst_shift_en", 32'(sen8), 32'd0);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_tail_sig", 32'(tsig8), 32'd0);
    chk("rst_match", 32'({m8, mv8}), 32'd0);
    chk("rst_busy4", 32'(busy4), 32'd0);
    prog_reset = 1'b0;
    tick();

    // Pass 1: 0xA5 into an empty chain
    sh = shifts8; dn = dones8;
    start_pass(1'b0);
    passq8.push_back(8'hA5);
    push_word(1'b0, 8'hA5);
    wait_done(1'b0, dn);
    chk("p1_shifts", 32'(shifts8 - sh), 32'd8);
    chk("p1_chain", 32'(chain8), 32'hA5);
    chk("p1_match_valid", 32'(mv8), 32'd0);
    chk("p1_busy_after", 32'(busy8), 32'd0);

    // Pass 2: 0x3C, start held high mid-pass must not restart it
    sh = shifts8; dn = dones8;
    start_pass(1'b0);
    passq8.push_back(8'h3C);
    start8 = 1'b1;
    push_word(1'b0, 8'h3C);
    repeat (3) tick();
    start8 = 1'b0;
    wait_done(1'b0, dn);
    chk("p2_shifts", 32'(shifts8 - sh), 32'd8);
    chk("p2_tail_sig", 32'(tsig8), 32'(crc8(8'hA5)));
    chk("p2_match_valid", 32'(mv8), 32'd1);
    chk("p2_match", 32'(m8), 32'd1);
    chk("p2_chain", 32'(chain8), 32'h3C);

    // Stuck-at-0 chain bit 3, two passes of 0xFF
    prog_reset = 1'b1; tick(); prog_reset = 1'b0; tick();
    stuck3 = 1'b1;
    for (int p = 0; p < 2; p++) begin
      dn = dones8;
      start_pass(1'b0);
      passq8.push_back(8'hFF);
      push_word(1'b0, 8'hFF);
      wait_done(1'b0, dn);
    end
    chk("stuck_match_valid", 32'(mv8), 32'd1);
    chk("stuck_match", 32'(m8), 32'd0);
    stuck3 = 1'b0;

    // Abort after three shifts
    sh = shifts8; dn = dones8; snap = chain8;
    start_pass(1'b0);
    passq8.push_back(8'h12);
    push_word(1'b0, 8'h12);
    wait_shifts(1'b0, sh, 3);
    abort8 = 1'b1;
    #1;
    chk("abort_shift_en", 32'(sen8), 32'd0);
    tick();
    abort8 = 1'b0;
    repeat (2) tick();
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_shifts", 32'(shifts8 - sh), 32'd3);
    chk("abort_no_done", 32'(dones8 - dn), 32'd0);
    chk("abort_match_valid", 32'(mv8), 32'd0);
    chk("abort_chain", 32'(chain8), 32'({snap[4:0], 3'b000}));

    // Abort together with cfg_valid in FETCH: word refused
    sh = shifts8;
    start_pass(1'b0);
    data8 = 8'h5A; cfg_valid8 = 1'b1; abort8 = 1'b1;
    tick();
    cfg_valid8 = 1'b0; abort8 = 1'b0;
    repeat (3) tick();
    chk("abort_fetch_busy", 32'(busy8), 32'd0);
    chk("abort_fetch_shifts", 32'(shifts8 - sh), 32'd0);

    // Reset in the middle of a pass
    sh = shifts8; dn = dones8;
    start_pass(1'b0);
    passq8.push_back(8'hC3);
    push_word(1'b0, 8'hC3);
    wait_shifts(1'b0, sh, 2);
    prog_reset = 1'b1;
    #1;
    chk("rst_mid_shift_en", 32'(sen8), 32'd0);
    tick();
    prog_reset = 1'b0;
    chk("rst_mid_busy", 32'(busy8), 32'd0);
    chk("rst_mid_outputs", 32'({ready8, done8, mv8, m8, tsig8}), 32'd0);
    repeat (3) tick();
    chk("rst_mid_no_done", 32'(dones8 - dn), 32'd0);

    // 4-bit words with a 5-cycle stall after the first word
    sh = shifts4; dn = dones4;
    start_pass(1'b1);
    passq4.push_back(8'hA5);
    push_word(1'b1, 8'h0A);
    wait_shifts(1'b1, sh, 4);
    snap = chain4;
    for (int i = 0; i < 5; i++) begin
      chk("stall_shift_en", 32'(sen4), 32'd0);
      chk("stall_ready", 32'(ready4), 32'd1);
      chk("stall_chain", 32'(chain4), 32'(snap));
      tick();
    end
    push_word(1'b1, 8'h05);
    wait_done(1'b1, dn);
    chk("w4_shifts", 32'(shifts4 - sh), 32'd8);
    chk("w4_chain", 32'(chain4), 32'hA5);
    chk("w4_match_valid", 32'(mv4), 32'd0);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
